fifo_rd_drain: RTL and testbench



---
 rtl/fifo_rd_drain.sv | 193 +++++++++++++++++++
 tb/tb_fifo_rd_drain.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_drain.sv
// -----------------------------------------------------------------------------
// fifo_rd_drain
// Read-side consumer for an async FIFO, living entirely in the read clock
// domain. FIFO reads are issued in bursts of BURST_LEN when the FIFO is not
// almost empty, or continuously while a flush is requested. Read data lands
// one cycle after rd_en in a 2-entry skid buffer. The buffer is re-presented
// on a valid/ready stream.
//
// Ports:
//   rd_clk        in   read-domain clock (posedge)
//   rstn          in   asynchronous active-low reset
//   rd_en         out  FIFO read enable
//   rd_data       in   FIFO read data, valid one cycle after rd_en
//   empty         in   FIFO empty flag
//   almost_empty  in   FIFO almost-empty flag
//   underflow     in   FIFO underflow flag
//   flush         in   level request: drain the FIFO to empty
//   out_valid     out  output word available
//   out_ready     in   downstream accepts the output word
//   out_data      out  output word (buffer head)
//   rd_count      out  total FIFO reads issued, wrapping
//   underflow_err out  sticky underflow indication
//   busy          out  FSM active, read in flight or buffer occupied
// -----------------------------------------------------------------------------
module fifo_rd_drain #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rstn,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  empty,
  input  logic                  almost_empty,
  input  logic                  underflow,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  underflow_err,
  output logic                  busy
);

  // Burst counter must be able to hold BURST_LEN itself.
  localparam int unsigned BCW = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e                state_q;
  logic [BCW-1:0]        burst_cnt_q;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] buf0_q, buf1_q;
  logic [DATA_WIDTH-1:0] buf0_d, buf1_d;
  logic [1:0]            occ_q, occ_d;
  logic [CNT_WIDTH-1:0]  rd_count_q;
  logic                  underflow_err_q;

  logic                  pop_s;
  logic [2:0]            credit_sum_s;
  logic                  credit_ok_s;
  logic                  burst_ok_s;
  logic                  rd_en_s;

  // Read-issue decision: credit counts the word popped this very cycle so
  // a full buffer with out_ready high still sustains one read per cycle.
  always_comb begin
    pop_s        = (occ_q != 2'd0) & out_ready;
    credit_sum_s = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_s};
    credit_ok_s  = (credit_sum_s < 3'd2);
    if (state_q == ST_BURST) begin
      burst_ok_s = (burst_cnt_q < BCW'(BURST_LEN));
    end else begin
      burst_ok_s = 1'b1;
    end
    rd_en_s = (state_q != ST_IDLE) & ~empty & credit_ok_s & burst_ok_s;
  end

  // Skid buffer next state: entry 0 is always the head, entry 1 the tail.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    occ_d  = occ_q;
    case ({inflight_q, pop_s})
      2'b10: begin
        if (occ_q == 2'd0) begin
          buf0_d = rd_data;
        end else begin
          buf1_d = rd_data;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Simultaneous land and pop: occupancy unchanged, order preserved.
        if (occ_q == 2'd1) begin
          buf0_d = rd_data;
        end else begin
          buf0_d = buf1_q;
          buf1_d = rd_data;
        end
      end
      default: begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        occ_d  = occ_q;
      end
    endcase
  end

  // Buffer, in-flight tracking, read counter and sticky error.
  always_ff @(posedge rd_clk or negedge rstn) begin
    if (!rstn) begin
      buf0_q          <= '0;
      buf1_q          <= '0;
      occ_q           <= 2'd0;
      inflight_q      <= 1'b0;
      rd_count_q      <= '0;
      underflow_err_q <= 1'b0;
    end else begin
      buf0_q          <= buf0_d;
      buf1_q          <= buf1_d;
      occ_q           <= occ_d;
      inflight_q      <= rd_en_s;
      rd_count_q      <= rd_count_q + {{(CNT_WIDTH-1){1'b0}}, rd_en_s};
      underflow_err_q <= underflow_err_q | underflow;
    end
  end

  // Control FSM and burst counter.
  always_ff @(posedge rd_clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      burst_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (flush & ~empty) begin
            state_q <= ST_FLUSH;
          end else if (~almost_empty) begin
            state_q     <= ST_BURST;
            burst_cnt_q <= '0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_BURST: begin
          // An empty FIFO simply stalls the burst; there is no timeout.
          if (flush) begin
            state_q <= ST_FLUSH;
          end else if (rd_en_s & (burst_cnt_q == BCW'(BURST_LEN - 1))) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_BURST;
          end
          if (rd_en_s) begin
            burst_cnt_q <= burst_cnt_q + {{(BCW-1){1'b0}}, 1'b1};
          end else begin
            burst_cnt_q <= burst_cnt_q;
          end
        end
        ST_FLUSH: begin
          // Leave only once nothing is left upstream or on the wire and
          // the request has been dropped.
          if (empty & ~inflight_q & ~flush) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_FLUSH;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rd_en         = rd_en_s;
  assign out_valid     = (occ_q != 2'd0);
  assign out_data      = buf0_q;
  assign rd_count      = rd_count_q;
  assign underflow_err = underflow_err_q;
  assign busy          = (state_q != ST_IDLE) | inflight_q | (occ_q != 2'd0);

endmodule

// File: tb/tb_fifo_rd_drain.sv
// -----------------------------------------------------------------------------
// Testbench for fifo_rd_drain. A queue stands in for the async FIFO. The
// reference model tracks words by content. Words handed out on rd_en are
// owed downstream, in order. Every one of them lands one cycle later. The
// model never mirrors the design's state machine.
// -----------------------------------------------------------------------------
module tb_fifo_rd_drain;

  localparam int DW = 8;
  localparam int BL = 4;
  localparam int CW = 4;

  logic          rd_clk;
  logic          rstn;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic          almost_empty;
  logic          underflow;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] rd_count;
  logic          underflow_err;
  logic          busy;

  fifo_rd_drain #(
    .DATA_WIDTH(DW),
    .BURST_LEN (BL),
    .CNT_WIDTH (CW)
  ) dut (
    .rd_clk       (rd_clk),
    .rstn         (rstn),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .empty        (empty),
    .almost_empty (almost_empty),
    .underflow    (underflow),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .rd_count     (rd_count),
    .underflow_err(underflow_err),
    .busy         (busy)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  int tests = 0;
  int fails = 0;

  // Source FIFO contents (bench-owned) and words owed downstream (model).
  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];
  // Logs written only by the compare process.
  logic [DW-1:0] pop_log_d[$];
  int            pop_log_c[$];
  int            rden_log_c[$];

  int            cyc_n = 0;
  int            buffered;
  bit            inflight_m;
  int            model_cnt;
  bit            model_uerr;
  bit            prev_hold;
  logic [DW-1:0] prev_data;
  bit            seen_rd_en;
  bit            force_empty;
  bit            force_ae_lo;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: checks outputs at negedge, then advances the model
  // across the coming posedge.
  always @(negedge rd_clk) begin
    cyc_n++;
    if (!rstn) begin
      exp_q.delete();
      inflight_m = 1'b0;
      model_cnt  = 0;
      model_uerr = 1'b0;
      prev_hold  = 1'b0;
      seen_rd_en = 1'b0;
    end else begin
      buffered = exp_q.size() - int'(inflight_m);
      check("rd_en_while_empty", {31'd0, rd_en & empty}, 32'd0);
      check("out_valid", {31'd0, out_valid}, {31'd0, buffered != 0});
      check("credit_bound", {31'd0, buffered <= 2}, 32'd1);
      if (buffered != 0) check("out_data", {24'd0, out_data}, {24'd0, exp_q[0]});
      if (prev_hold) check("hold_stable", {24'd0, out_data}, {24'd0, prev_data});
      check("rd_count", {28'd0, rd_count}, model_cnt % (1 << CW));
      check("underflow_err", {31'd0, underflow_err}, {31'd0, model_uerr});
      prev_hold = (buffered != 0) && !out_ready;
      prev_data = out_data;
      if (buffered != 0 && out_ready) begin
        pop_log_d.push_back(exp_q.pop_front());
        pop_log_c.push_back(cyc_n);
      end
      if (rd_en) begin
        if (src_q.size() > 0) exp_q.push_back(src_q[0]);
        model_cnt++;
        rden_log_c.push_back(cyc_n);
      end
      inflight_m = rd_en;
      model_uerr = model_uerr | underflow;
      seen_rd_en = rd_en;
    end
  end

  task automatic upd();
    empty        = (src_q.size() == 0) || force_empty;
    almost_empty = force_ae_lo ? 1'b0 : (src_q.size() <= BL);
  endtask

  // Advance n cycles; the FIFO answers an accepted read one cycle later.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge rd_clk);
      #1;
      if (seen_rd_en && src_q.size() > 0) rd_data = src_q.pop_front();
      else rd_data = DW'($urandom);
      upd();
    end
  endtask

  task automatic load(input logic [DW-1:0] first, input int n);
    for (int i = 0; i < n; i++) src_q.push_back(first + DW'(i));
    upd();
  endtask

  task automatic do_reset();
    #2;
    rstn        = 1'b0;
    src_q.delete();
    flush       = 1'b0;
    underflow   = 1'b0;
    out_ready   = 1'b0;
    force_empty = 1'b0;
    force_ae_lo = 1'b0;
    upd();
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_rd_count", {28'd0, rd_count}, 32'd0);
    check("rst_underflow_err", {31'd0, underflow_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rd_en", {31'd0, rd_en}, 32'd0);
    repeat (2) @(posedge rd_clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic check_pops(input string name, input int base, input logic [DW-1:0] first, input int n);
    check({name, "_count"}, pop_log_d.size() - base, n);
    if (pop_log_d.size() >= base + n) begin
      for (int i = 0; i < n; i++)
        check({name, "_data"}, {24'd0, pop_log_d[base+i]}, {24'd0, first + DW'(i)});
    end
  endtask

  initial begin
    int base_p;
    int base_r;
    int n_loaded;
    rstn        = 1'b0;
    rd_data     = '0;
    flush       = 1'b0;
    underflow   = 1'b0;
    out_ready   = 1'b0;
    force_empty = 1'b0;
    force_ae_lo = 1'b0;
    upd();

    // Burst: four back-to-back reads, words out on consecutive cycles.
    do_reset();
    out_ready = 1'b1;
    base_p = pop_log_d.size();
    base_r = rden_log_c.size();
    load(8'h10, 8);
    cyc(15);
    check("burst_reads", rden_log_c.size() - base_r, 4);
    if (rden_log_c.size() >= base_r + 4)
      for (int i = 1; i < 4; i++)
        check("burst_rd_en_consec", rden_log_c[base_r+i] - rden_log_c[base_r+i-1], 1);
    check_pops("burst_pops", base_p, 8'h10, 4);
    if (pop_log_c.size() >= base_p + 4)
      for (int i = 1; i < 4; i++)
        check("burst_pop_consec", pop_log_c[base_p+i] - pop_log_c[base_p+i-1], 1);
    check("burst_rd_count", {28'd0, rd_count}, 32'd4);
    check("burst_idle", {31'd0, busy}, 32'd0);

    // Backpressure: two words buffered, head held, then in-order release.
    do_reset();
    base_p = pop_log_d.size();
    load(8'h10, 8);
    cyc(10);
    check("bp_rd_count", {28'd0, rd_count}, 32'd2);
    check("bp_valid", {31'd0, out_valid}, 32'd1);
    check("bp_head", {24'd0, out_data}, 32'h10);
    out_ready = 1'b1;
    cyc(15);
    check_pops("bp_pops", base_p, 8'h10, 4);
    check("bp_rd_count_end", {28'd0, rd_count}, 32'd4);

    // Flush: one-cycle pulse drains three words below the burst threshold.
    do_reset();
    out_ready = 1'b1;
    base_p = pop_log_d.size();
    base_r = rden_log_c.size();
    load(8'h20, 3);
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    cyc(15);
    check("flush_reads", rden_log_c.size() - base_r, 3);
    check_pops("flush_pops", base_p, 8'h20, 3);
    check("flush_busy", {31'd0, busy}, 32'd0);

    // Empty stall: burst pauses on empty, resumes for the last two reads.
    do_reset();
    out_ready   = 1'b1;
    force_ae_lo = 1'b1;
    base_p = pop_log_d.size();
    load(8'h30, 2);
    cyc(8);
    check("stall_rd_count", {28'd0, rd_count}, 32'd2);
    check("stall_busy", {31'd0, busy}, 32'd1);
    force_ae_lo = 1'b0;
    load(8'h32, 2);
    cyc(10);
    check("stall_rd_count_end", {28'd0, rd_count}, 32'd4);
    check_pops("stall_pops", base_p, 8'h30, 4);
    check("stall_busy_end", {31'd0, busy}, 32'd0);

    // Underflow is sticky; reset mid-burst with two buffered words clears all.
    do_reset();
    underflow = 1'b1;
    cyc(1);
    underflow = 1'b0;
    cyc(2);
    check("uflow_set", {31'd0, underflow_err}, 32'd1);
    cyc(5);
    check("uflow_sticky", {31'd0, underflow_err}, 32'd1);
    load(8'h40, 8);
    cyc(6);
    check("midburst_valid", {31'd0, out_valid}, 32'd1);
    check("midburst_rd_count", {28'd0, rd_count}, 32'd2);
    do_reset();

    // Wrap: 18 reads on a 4-bit counter leave 2.
    out_ready = 1'b1;
    base_p = pop_log_d.size();
    load(8'h50, 18);
    flush = 1'b1;
    for (int k = 0; k < 100 && src_q.size() > 0; k++) cyc(1);
    check("wrap_drained", src_q.size(), 0);
    flush = 1'b0;
    cyc(10);
    check("wrap_rd_count", {28'd0, rd_count}, 32'd2);
    check_pops("wrap_pops", base_p, 8'h50, 18);

    // Random traffic against the model, then a bounded flush drain.
    do_reset();
    base_p   = pop_log_d.size();
    n_loaded = 0;
    for (int c = 0; c < 3000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      underflow = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 5) == 0 && src_q.size() < 20) begin
        int n;
        n = $urandom_range(1, 6);
        for (int i = 0; i < n; i++) src_q.push_back(DW'($urandom));
        n_loaded += n;
        upd();
      end
      cyc(1);
    end
    underflow = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b1;
    for (int k = 0; k < 300 && (src_q.size() > 0 || exp_q.size() > 0); k++) cyc(1);
    check("rand_src_drained", src_q.size(), 0);
    check("rand_all_delivered", exp_q.size(), 0);
    flush = 1'b0;
    cyc(5);
    check("rand_pop_total", pop_log_d.size() - base_p, n_loaded);
    check("rand_busy_end", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1);
  end

endmodule
